// File: rtl/sreg_xfer.sv
// ----------------------------------------------------------------------------
// sreg_xfer
//   Parallel-in/serial-out shift register with a small transfer controller.
//   A START request in IDLE loads a WIDTH-bit word, shifts it out one bit per
//   clock (LSB-first or MSB-first), then raises DONE for one cycle.
//
//   Build option:
//     SREG_XFER_ROTATE_EN  - when defined, the vacated bit is refilled with
//                            the outgoing bit, so the transfer is a rotate and
//                            Q returns to the loaded word. SIN is ignored.
//                            When undefined, the vacated bit is filled from SIN.
//
//   Ports:
//     CLK    in   1      clock, rising edge
//     RST    in   1      synchronous active-high reset
//     START  in   1      transfer request, sampled only in IDLE
//     DIR    in   1      0 = shift right (LSB first), 1 = shift left (MSB first)
//     D      in   WIDTH  parallel load word, sampled with START
//     SIN    in   1      serial fill bit, used live on every shift
//     Q      out  WIDTH  register contents
//     SOUT   out  1      serial output bit (valid while BUSY)
//     BUSY   out  1      high while shifting
//     DONE   out  1      one-cycle pulse after the last shift
// ----------------------------------------------------------------------------
module sreg_xfer #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             DIR,
    input  logic [WIDTH-1:0] D,
    input  logic             SIN,
    output logic [WIDTH-1:0] Q,
    output logic             SOUT,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q, q_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             dir_q, dir_nxt;
    logic             out_bit;
    logic             fill;

    // Bit leaving the register on the next shift, chosen by the latched direction.
    assign out_bit = dir_q ? q[WIDTH-1] : q[0];

`ifdef SREG_XFER_ROTATE_EN
    logic unused_sin;
    assign unused_sin = SIN;
    assign fill       = out_bit;
`else
    assign fill       = SIN;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            q     <= '0;
            cnt   <= '0;
            dir_q <= 1'b0;
        end else begin
            state <= state_nxt;
            q     <= q_nxt;
            cnt   <= cnt_nxt;
            dir_q <= dir_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        cnt_nxt   = cnt;
        dir_nxt   = dir_q;
        SOUT      = 1'b0;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        case (state)
            S_IDLE: begin
                if (START) begin
                    q_nxt     = D;
                    dir_nxt   = DIR;
                    cnt_nxt   = '0;
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                BUSY    = 1'b1;
                SOUT    = out_bit;
                q_nxt   = dir_q ? {q[WIDTH-2:0], fill} : {fill, q[WIDTH-1:1]};
                cnt_nxt = cnt + CW'(1);
                // cnt counts shifts already done, so WIDTH-1 marks the final one.
                if (cnt == CNT_LAST) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                DONE      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign Q = q;

endmodule

// File: tb/tb_sreg_xfer.sv
module tb_sreg_xfer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, dir, sin;
    logic [7:0] d;
    logic [7:0] q;
    logic       sout, busy, done;

    logic       start2, dir2, sin2;
    logic [1:0] d2;
    logic [1:0] q2;
    logic       sout2, busy2, done2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sreg_xfer #(.WIDTH(8)) dut (
        .CLK(clk), .RST(rst), .START(start), .DIR(dir), .D(d), .SIN(sin),
        .Q(q), .SOUT(sout), .BUSY(busy), .DONE(done)
    );

    sreg_xfer #(.WIDTH(2)) dut2 (
        .CLK(clk), .RST(rst), .START(start2), .DIR(dir2), .D(d2), .SIN(sin2),
        .Q(q2), .SOUT(sout2), .BUSY(busy2), .DONE(done2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs a full transfer on the 8-bit instance from IDLE and checks the
    // serial stream, BUSY/DONE timing and the final register value.
    task automatic run8(input string tag, input logic [7:0] word, input logic dr,
                        input logic s, input logic [7:0] sout_exp, input logic [7:0] q_exp);
        d = word; dir = dr; sin = s; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_busy"}, busy, 1'b1);
            chk({tag, "_sout"}, sout, sout_exp[7-i]);
            chk({tag, "_done_low"}, done, 1'b0);
            tick();
        end
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_busy_in_done"}, busy, 1'b0);
        chk({tag, "_q"}, q, q_exp);
        tick();
        chk({tag, "_idle_done"}, done, 1'b0);
        chk({tag, "_idle_sout"}, sout, 1'b0);
    endtask

    int         done_at[$];
    logic [63:0] busy_hist;
    int         overlap;
    int         busy_low;

    initial begin
        rst = 1'b1; start = 1'b0; dir = 1'b0; sin = 1'b0; d = '0;
        start2 = 1'b0; dir2 = 1'b0; sin2 = 1'b0; d2 = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_q", q, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sout", sout, 1'b0);

        // Stream expectations are written in transmission order, first bit in [7].
        // Test 1: A5 LSB-first, SIN=0.
`ifdef SREG_XFER_ROTATE_EN
        run8("t1", 8'hA5, 1'b0, 1'b0, 8'b1010_0101, 8'hA5);
`else
        run8("t1", 8'hA5, 1'b0, 1'b0, 8'b1010_0101, 8'h00);
`endif

        // Test 2: 81 MSB-first, SIN=1.
`ifdef SREG_XFER_ROTATE_EN
        run8("t2", 8'h81, 1'b1, 1'b1, 8'b1000_0001, 8'h81);
`else
        run8("t2", 8'h81, 1'b1, 1'b1, 8'b1000_0001, 8'hFF);
`endif

        // Test 3: START with a new word in the 3rd SHIFT cycle is ignored.
        d = 8'h3C; dir = 1'b0; sin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t3_busy", busy, 1'b1);
            chk("t3_sout", sout, 1'((8'h3C >> i) & 8'h01));
            if (i == 2) begin
                start = 1'b1; d = 8'hFF; dir = 1'b1; sin = 1'b1;
            end else begin
                start = 1'b0; sin = 1'b0;
            end
            tick();
        end
        chk("t3_done", done, 1'b1);
`ifdef SREG_XFER_ROTATE_EN
        chk("t3_q", q, 8'h3C);
`else
        // SIN was 1 only during the 3rd shift, landing at bit 7-5 = 2.
        chk("t3_q", q, 8'h04);
`endif
        tick();
        chk("t3_idle", done, 1'b0);
        chk("t3_idle_busy", busy, 1'b0);

        // Test 4: reset in the 4th SHIFT cycle aborts without DONE.
        d = 8'h5A; dir = 1'b0; sin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("t4_busy_before_rst", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_q", q, 8'h00);
        chk("t4_busy", busy, 1'b0);
        chk("t4_sout", sout, 1'b0);
        chk("t4_done", done, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_no_done", done, 1'b0);
        end
`ifdef SREG_XFER_ROTATE_EN
        run8("t4b", 8'hC3, 1'b1, 1'b0, 8'b1100_0011, 8'hC3);
`else
        run8("t4b", 8'hC3, 1'b1, 1'b0, 8'b1100_0011, 8'h00);
`endif

        // Test 5: START held high gives back-to-back transfers every 10 cycles.
        d = 8'h01; dir = 1'b0; sin = 1'b0; start = 1'b1;
        overlap = 0;
        busy_hist = '0;
        for (int c = 0; c < 40; c++) begin
            tick();
            busy_hist[c] = busy;
            if (busy && done) overlap++;
            if (done) done_at.push_back(c);
        end
        start = 1'b0;
        chk("t5_overlap", 32'(overlap), 32'd0);
        chk("t5_done_count", 32'(done_at.size()), 32'd4);
        if (done_at.size() >= 3) begin
            chk("t5_gap1", 32'(done_at[1] - done_at[0]), 32'd10);
            chk("t5_gap2", 32'(done_at[2] - done_at[1]), 32'd10);
            busy_low = 0;
            for (int c = done_at[0]; c < done_at[1]; c++) begin
                if (!busy_hist[c]) busy_low++;
            end
            chk("t5_busy_low", 32'(busy_low), 32'd2);
        end
        for (int i = 0; i < 12; i++) tick();
        chk("t5_drained_busy", busy, 1'b0);

        // Test 6: WIDTH=2 instance, D=10, LSB-first, SIN=1.
        d2 = 2'b10; dir2 = 1'b0; sin2 = 1'b1; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("t6_busy1", busy2, 1'b1);
        chk("t6_sout1", sout2, 1'b0);
        tick();
        chk("t6_busy2", busy2, 1'b1);
        chk("t6_sout2", sout2, 1'b1);
        tick();
        chk("t6_done", done2, 1'b1);
        chk("t6_busy3", busy2, 1'b0);
`ifdef SREG_XFER_ROTATE_EN
        chk("t6_q", q2, 2'b10);
`else
        chk("t6_q", q2, 2'b11);
`endif
        tick();
        chk("t6_idle", done2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
